alu_serial_sequencer: RTL and testbench

Bit-serial ALU controller that computes a WIDTH-bit operation by driving one existing 1-bit ALU slice for WIDTH consecutive cycles, LSB first. The slice's carry-out is fed back as its carry-in on the next cycle. Operands are accepted on a valid/ready input handshake, and the result is returned on a valid/ready output handshake. It sits between the register/decode logic and the shared 1-bit ALU datapath and replaces a WIDTH-wide ripple ALU where area matters.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_serial_sequencer_if.sv | 25 ++
 rtl/alu_serial_sequencer_alu1.sv | 32 +++
 rtl/alu_serial_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_serial_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-classification helpers for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] SUB = 3'd3;
  localparam logic [2:0] AND = 3'd4;
  localparam logic [2:0] OR  = 3'd5;
  localparam logic [2:0] NOR = 3'd6;
  localparam logic [2:0] XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] ctl);
    return (ctl >= ADD);
  endfunction

  function automatic logic is_arith_op(input logic [2:0] ctl);
    return (ctl == ADD) || (ctl == SUB);
  endfunction

endpackage

// File: rtl/alu_serial_sequencer_if.sv
// Operand/result handshake bundle between decode logic (master) and the serial ALU (slave).
interface alu_serial_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, control, out_ready,
    input  in_ready, out_valid, out, carryout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, control, out_ready,
    output in_ready, out_valid, out, carryout, overflow, zero, negative
  );
endinterface

// File: rtl/alu_serial_sequencer_alu1.sv
// Existing 1-bit ALU slice: combinational, SUB inverts b and relies on carry-in=1 at the LSB.
module alu1
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       out,
  output logic       carryout
);

  logic b_eff;

  always_comb begin
    b_eff    = (control == SUB) ? ~b : b;
    out      = 1'b0;
    carryout = 1'b0;
    case (control)
      ADD, SUB: begin
        out      = a ^ b_eff ^ carryin;
        carryout = (a & b_eff) | (a & carryin) | (b_eff & carryin);
      end
      AND:     out = a & b;
      OR:      out = a | b;
      NOR:     out = ~(a | b);
      XOR:     out = a ^ b;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: one alu1 slice stepped LSB first for WIDTH cycles; result held until out_ready.
// `define ALU_SERIAL_PERF_EN to add a saturating op_count of output handshakes.
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  alu_serial_if.slave bus
`ifdef ALU_SERIAL_PERF_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, out_q, out_d;
  logic [2:0]       ctl_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             co_q, ov_q, zero_q, neg_q;
  logic             slice_out, slice_co;
  logic             last_bit;

  alu1 u_slice (
    .a        (a_q[idx_q]),
    .b        (b_q[idx_q]),
    .carryin  (carry_q),
    .control  (ctl_q),
    .out      (slice_out),
    .carryout (slice_co)
  );

  assign last_bit = (idx_q == LAST_IDX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = is_legal_op(bus.control) ? RUN : DONE;
      RUN:     if (last_bit)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    out_d        = out_q;
    out_d[idx_q] = slice_out;
  end

  // Flags are captured on the final bit so they are stable for the whole DONE phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          ctl_q   <= bus.control;
          idx_q   <= '0;
          carry_q <= (bus.control == SUB);
          out_q   <= '0;
          co_q    <= 1'b0;
          ov_q    <= 1'b0;
          neg_q   <= 1'b0;
          zero_q  <= ~is_legal_op(bus.control);
        end
        RUN: begin
          out_q   <= out_d;
          carry_q <= slice_co;
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            co_q   <= is_arith_op(ctl_q) & slice_co;
            ov_q   <= is_arith_op(ctl_q) & (carry_q ^ slice_co);
            neg_q  <= slice_out;
            zero_q <= ~|out_d;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.carryout = co_q;
  assign bus.overflow = ov_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;

`ifdef ALU_SERIAL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                op_count <= '0;
    else if (bus.out_valid && bus.out_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed + scoreboard bench for alu_serial_sequencer at WIDTH=8.
module tb_alu_serial_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] out;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
    int           lat;
  } exp_t;

  logic clock;
  logic reset;
  alu_serial_if #(.WIDTH(W)) bus ();
`ifdef ALU_SERIAL_PERF_EN
  logic [15:0] op_count;
`endif

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_SERIAL_PERF_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctl);
    exp_t     e;
    logic [W:0] s;
    e.out = '0; e.co = 1'b0; e.ov = 1'b0; e.lat = W + 1;
    case (ctl)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.out = s[W-1:0]; e.co = s[W];
        e.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        e.out = s[W-1:0]; e.co = s[W];
        e.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      AND: e.out = a & b;
      OR:  e.out = a | b;
      NOR: e.out = ~(a | b);
      XOR: e.out = a ^ b;
      default: begin e.out = '0; e.lat = 1; end
    endcase
    e.z = (e.out == '0);
    e.n = e.out[W-1];
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctl);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clock); #1; t++;
    end
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.control = ctl;
    sb.push_back(model(a, b, ctl));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.control = XOR;
  endtask

  task automatic wait_check(input string tag);
    int   cyc = 1;
    exp_t e;
    while (!bus.out_valid && cyc < 64) begin
      @(posedge clock); #1; cyc++;
    end
    chk({tag, "_sb_nonempty"}, sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_out"}, {24'd0, bus.out}, {24'd0, e.out});
      chk({tag, "_carryout"}, {31'd0, bus.carryout}, {31'd0, e.co});
      chk({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.ov});
      chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e.z});
      chk({tag, "_negative"}, {31'd0, bus.negative}, {31'd0, e.n});
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    hs_cnt++;
    chk({tag, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctl);
    send(a, b, ctl);
    wait_check(tag);
    consume(tag);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_out"}, {24'd0, bus.out}, 32'd0);
    chk({tag, "_flags"}, {28'd0, bus.carryout, bus.overflow, bus.zero, bus.negative}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] hold_out;
    logic [3:0]   hold_flags;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.control = '0;
    repeat (3) @(posedge clock);
    #1;
    check_cleared("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("add_7f_01", 8'h7F, 8'h01, ADD);
    run_op("sub_05_05", 8'h05, 8'h05, SUB);
    run_op("sub_00_01", 8'h00, 8'h01, SUB);
    run_op("xor_a5_ff", 8'hA5, 8'hFF, XOR);
    run_op("nor_00_00", 8'h00, 8'h00, NOR);
    run_op("and_f0_3c", 8'hF0, 8'h3C, AND);
    run_op("or_81_18",  8'h81, 8'h18, OR);
    run_op("add_ff_ff", 8'hFF, 8'hFF, ADD);
    run_op("sub_80_01", 8'h80, 8'h01, SUB);

    for (int k = 0; k < 4; k++)
      run_op("rand_op", W'($urandom), W'($urandom), 3'($urandom_range(2, 7)));

    // Backpressure: result must hold and no new op may be taken while DONE.
    send(8'h12, 8'h34, ADD);
    wait_check("bp");
    hold_out   = bus.out;
    hold_flags = {bus.carryout, bus.overflow, bus.zero, bus.negative};
    bus.in_valid = 1'b1; bus.a = 8'h55; bus.b = 8'h0F; bus.control = SUB;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_stable", {24'd0, bus.out}, {24'd0, hold_out});
      chk("bp_flags_stable", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.negative}, {28'd0, hold_flags});
    end
    bus.in_valid = 1'b0;
    consume("bp");
    @(posedge clock); #1;
    chk("bp_no_accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_no_accept_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of RUN at bit index 3.
    send(8'h3C, 8'h5A, ADD);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("midrun_reset");
    void'(sb.pop_front());
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    run_op("post_reset_add", 8'h01, 8'h01, ADD);

    run_op("illegal_op0", 8'hAB, 8'hCD, 3'd0);
    run_op("illegal_op1", 8'h11, 8'h22, 3'd1);

`ifdef ALU_SERIAL_PERF_EN
    chk("op_count", {16'd0, op_count}, hs_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
